// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control unit / memory and mem_access_unit.
interface mem_access_unit_if;
  logic [15:0] ADDR;
  logic        LD_MAR;
  logic        MIO_EN;
  logic        R_W;
  logic        DATA_SIZE;
  logic [15:0] WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_R;
  logic [15:0] MEM_ADDR;
  logic        MEM_EN;
  logic [1:0]  MEM_WE;
  logic [15:0] MEM_WDATA;
  logic [15:0] MDR;
  logic        R;
  logic        BUSY;
  logic        UNALIGNED;
  logic        TIMEOUT_ERR;

  modport slave (
    input  ADDR, LD_MAR, MIO_EN, R_W, DATA_SIZE, WDATA, MEM_RDATA, MEM_R,
    output MEM_ADDR, MEM_EN, MEM_WE, MEM_WDATA, MDR, R, BUSY, UNALIGNED, TIMEOUT_ERR
  );

  modport master (
    output ADDR, LD_MAR, MIO_EN, R_W, DATA_SIZE, WDATA, MEM_RDATA, MEM_R,
    input  MEM_ADDR, MEM_EN, MEM_WE, MEM_WDATA, MDR, R, BUSY, UNALIGNED, TIMEOUT_ERR
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR, byte/word lane steering, wait-state timeout
// and unaligned-word detection for a 16-bit datapath.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ABORT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] mar, mdr, wdata_q;
  logic        rw_q, size_q, abort_unal_q;
  logic [7:0]  wait_cnt;
  logic        addr_lsb, unal_det;
  logic [15:0] rd_val;

  // Alignment check must see the address being loaded on this same edge.
  assign addr_lsb = bus.LD_MAR ? bus.ADDR[0] : mar[0];

  // Read result: full word, or selected byte sign-extended.
  always_comb begin
    rd_val = bus.MEM_RDATA;
    if (!size_q) begin
      if (mar[0]) rd_val = {{8{bus.MEM_RDATA[15]}}, bus.MEM_RDATA[15:8]};
      else        rd_val = {{8{bus.MEM_RDATA[7]}},  bus.MEM_RDATA[7:0]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and abort-cause detection.
  always_comb begin
    state_nxt = state;
    unal_det  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MIO_EN) begin
          if (bus.DATA_SIZE && addr_lsb) begin
            state_nxt = ABORT;
            unal_det  = 1'b1;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.MEM_R)                  state_nxt = DONE;
        else if (wait_cnt == TO_LAST)   state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: MAR, latched request, wait counter, MDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar          <= '0;
      mdr          <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      size_q       <= 1'b0;
      abort_unal_q <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.LD_MAR) mar <= bus.ADDR;
        if (bus.MIO_EN) begin
          rw_q         <= bus.R_W;
          size_q       <= bus.DATA_SIZE;
          wdata_q      <= bus.WDATA;
          abort_unal_q <= unal_det;
          wait_cnt     <= '0;
        end
      end
      if (state == ACCESS) begin
        if (!bus.MEM_R) wait_cnt <= wait_cnt + 8'd1;
        else if (!rw_q) mdr <= rd_val;
      end
    end
  end

  // Outputs decoded from state so reset clears them without waiting for an edge.
  always_comb begin
    bus.MEM_ADDR    = mar;
    bus.MEM_EN      = (state == ACCESS);
    bus.MEM_WE      = 2'b00;
    if (state == ACCESS && rw_q) begin
      if (size_q)      bus.MEM_WE = 2'b11;
      else if (mar[0]) bus.MEM_WE = 2'b10;
      else             bus.MEM_WE = 2'b01;
    end
    bus.MEM_WDATA   = size_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
    bus.MDR         = mdr;
    bus.R           = (state == DONE);
    bus.BUSY        = (state != IDLE);
    bus.UNALIGNED   = (state == ABORT) && abort_unal_q;
    bus.TIMEOUT_ERR = (state == ABORT) && !abort_unal_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4.
module tb_mem_access_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-access observations gathered over a fixed 12-cycle window.
  int          en_cycles, r_cnt, r_at, unal_cnt, terr_cnt;
  logic [1:0]  we_seen;
  logic [15:0] wd_seen, addr_seen;

  // Issue one request (with LD_MAR) at the next edge and watch 12 cycles.
  // ready_at = ACCESS cycle index with MEM_R high, 0 = never.
  task automatic run_access(input logic [15:0] addr, input logic rw, input logic size,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input int ready_at);
    en_cycles = 0; r_cnt = 0; r_at = 0; unal_cnt = 0; terr_cnt = 0;
    we_seen = 2'bxx; wd_seen = 'x; addr_seen = 'x;
    bus.ADDR = addr; bus.LD_MAR = 1'b1; bus.MIO_EN = 1'b1;
    bus.R_W = rw; bus.DATA_SIZE = size; bus.WDATA = wdata;
    @(posedge clk); #1;
    bus.LD_MAR = 1'b0; bus.MIO_EN = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      bus.MEM_R = (cyc == ready_at);
      bus.MEM_RDATA = rdata;
      @(negedge clk);
      if (bus.MEM_EN) begin
        en_cycles++; we_seen = bus.MEM_WE; wd_seen = bus.MEM_WDATA; addr_seen = bus.MEM_ADDR;
      end
      if (bus.R) begin r_cnt++; r_at = cyc; end
      if (bus.UNALIGNED) unal_cnt++;
      if (bus.TIMEOUT_ERR) terr_cnt++;
      @(posedge clk); #1;
    end
    bus.MEM_R = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.ADDR = '0; bus.LD_MAR = 0; bus.MIO_EN = 0; bus.R_W = 0; bus.DATA_SIZE = 0;
    bus.WDATA = '0; bus.MEM_RDATA = '0; bus.MEM_R = 0;
    #2;
    checks++;
    if ({bus.MEM_EN, bus.MEM_WE, bus.R, bus.BUSY, bus.UNALIGNED, bus.TIMEOUT_ERR} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0",
        {bus.MEM_EN, bus.MEM_WE, bus.R, bus.BUSY, bus.UNALIGNED, bus.TIMEOUT_ERR});
    end
    checks++;
    if ({bus.MDR, bus.MEM_ADDR, bus.MEM_WDATA} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", bus.MDR, bus.MEM_ADDR, bus.MEM_WDATA);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_read;
    run_access(16'h3000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 3);
    checks++; if (en_cycles !== 3) begin errors++; $display("FAIL wr_en_cycles got %0d exp 3", en_cycles); end
    checks++; if (addr_seen !== 16'h3000) begin errors++; $display("FAIL wr_addr got %h exp 3000", addr_seen); end
    checks++; if (we_seen !== 2'b00) begin errors++; $display("FAIL wr_we got %b exp 00", we_seen); end
    checks++; if (bus.MDR !== 16'hBEEF) begin errors++; $display("FAIL wr_mdr got %h exp beef", bus.MDR); end
    checks++; if (r_cnt !== 1 || r_at !== 4) begin errors++; $display("FAIL wr_r got cnt %0d at %0d exp 1 at 4", r_cnt, r_at); end
  endtask

  task automatic test_byte_read;
    run_access(16'h3001, 1'b0, 1'b0, 16'h0000, 16'h80AA, 1);
    checks++; if (bus.MDR !== 16'hFF80) begin errors++; $display("FAIL br_odd_neg got %h exp ff80", bus.MDR); end
    checks++; if (r_at !== 2) begin errors++; $display("FAIL br_latency got %0d exp 2", r_at); end
    run_access(16'h3001, 1'b0, 1'b0, 16'h0000, 16'h7FAA, 2);
    checks++; if (bus.MDR !== 16'h007F) begin errors++; $display("FAIL br_odd_pos got %h exp 007f", bus.MDR); end
    run_access(16'h3002, 1'b0, 1'b0, 16'h0000, 16'h12F0, 1);
    checks++; if (bus.MDR !== 16'hFFF0) begin errors++; $display("FAIL br_even got %h exp fff0", bus.MDR); end
    run_access(16'h3004, 1'b0, 1'b0, 16'h0000, 16'hF07F, 1);
    checks++; if (bus.MDR !== 16'h007F) begin errors++; $display("FAIL br_even_pos got %h exp 007f", bus.MDR); end
  endtask

  task automatic test_write;
    run_access(16'h4001, 1'b1, 1'b0, 16'h1234, 16'hAAAA, 2);
    checks++; if (we_seen !== 2'b10) begin errors++; $display("FAIL bw_odd_we got %b exp 10", we_seen); end
    checks++; if (wd_seen !== 16'h3434) begin errors++; $display("FAIL bw_wdata got %h exp 3434", wd_seen); end
    checks++; if (bus.MDR !== 16'h007F) begin errors++; $display("FAIL bw_mdr got %h exp 007f", bus.MDR); end
    checks++; if (r_cnt !== 1) begin errors++; $display("FAIL bw_r got %0d exp 1", r_cnt); end
    run_access(16'h4000, 1'b1, 1'b0, 16'h56C7, 16'hAAAA, 1);
    checks++; if (we_seen !== 2'b01 || wd_seen !== 16'hC7C7) begin
      errors++; $display("FAIL bw_even got %b %h exp 01 c7c7", we_seen, wd_seen); end
    run_access(16'h4002, 1'b1, 1'b1, 16'hABCD, 16'hAAAA, 1);
    checks++; if (we_seen !== 2'b11 || wd_seen !== 16'hABCD) begin
      errors++; $display("FAIL ww got %b %h exp 11 abcd", we_seen, wd_seen); end
    checks++; if (bus.MDR !== 16'h007F) begin errors++; $display("FAIL ww_mdr got %h exp 007f", bus.MDR); end
  endtask

  task automatic test_unaligned;
    run_access(16'h4001, 1'b1, 1'b1, 16'h9999, 16'h0000, 1);
    checks++; if (en_cycles !== 0) begin errors++; $display("FAIL ua_en got %0d exp 0", en_cycles); end
    checks++; if (unal_cnt !== 1) begin errors++; $display("FAIL ua_pulse got %0d exp 1", unal_cnt); end
    checks++; if (r_cnt !== 0 || terr_cnt !== 0) begin
      errors++; $display("FAIL ua_other got r %0d terr %0d exp 0 0", r_cnt, terr_cnt); end
  endtask

  task automatic test_timeout;
    run_access(16'h2000, 1'b0, 1'b1, 16'h0000, 16'h5555, 0);
    checks++; if (en_cycles !== 4) begin errors++; $display("FAIL to_en got %0d exp 4", en_cycles); end
    checks++; if (terr_cnt !== 1 || r_cnt !== 0 || unal_cnt !== 0) begin
      errors++; $display("FAIL to_flags got terr %0d r %0d ua %0d exp 1 0 0", terr_cnt, r_cnt, unal_cnt); end
    checks++; if (bus.MDR !== 16'h007F) begin errors++; $display("FAIL to_mdr got %h exp 007f", bus.MDR); end
    run_access(16'h2000, 1'b0, 1'b1, 16'h0000, 16'h1357, 4);
    checks++; if (r_cnt !== 1 || r_at !== 5 || terr_cnt !== 0) begin
      errors++; $display("FAIL to_last got r %0d at %0d terr %0d exp 1 5 0", r_cnt, r_at, terr_cnt); end
    checks++; if (bus.MDR !== 16'h1357) begin errors++; $display("FAIL to_last_mdr got %h exp 1357", bus.MDR); end
  endtask

  task automatic test_busy_ignore;
    bus.ADDR = 16'h5000; bus.LD_MAR = 1; bus.MIO_EN = 1; bus.R_W = 0; bus.DATA_SIZE = 1;
    @(posedge clk); #1;
    bus.ADDR = 16'h6000;
    bus.MEM_R = 0;
    @(negedge clk);
    checks++; if (bus.MEM_ADDR !== 16'h5000) begin errors++; $display("FAIL bi_mar got %h exp 5000", bus.MEM_ADDR); end
    @(posedge clk); #1;
    bus.MEM_R = 1; bus.MEM_RDATA = 16'h2468;
    @(posedge clk); #1;
    bus.MEM_R = 0;
    checks++; if (bus.R !== 1'b1) begin errors++; $display("FAIL bi_r got %b exp 1", bus.R); end
    @(posedge clk); #1;
    bus.LD_MAR = 0; bus.MIO_EN = 0;
    checks++; if (bus.BUSY !== 1'b0 || bus.MEM_ADDR !== 16'h5000 || bus.MDR !== 16'h2468) begin
      errors++; $display("FAIL bi_idle got busy %b addr %h mdr %h exp 0 5000 2468", bus.BUSY, bus.MEM_ADDR, bus.MDR); end
  endtask

  task automatic test_reset_mid;
    int r_seen;
    r_seen = 0;
    bus.ADDR = 16'h3000; bus.LD_MAR = 1; bus.MIO_EN = 1; bus.R_W = 0; bus.DATA_SIZE = 1;
    bus.MEM_R = 0;
    @(posedge clk); #1;
    bus.LD_MAR = 0; bus.MIO_EN = 0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.MEM_EN, bus.MEM_WE, bus.R, bus.BUSY, bus.UNALIGNED, bus.TIMEOUT_ERR} !== 7'b0 ||
        bus.MDR !== 16'h0 || bus.MEM_ADDR !== 16'h0) begin
      errors++; $display("FAIL rm_outputs got en %b we %b busy %b mdr %h addr %h exp all 0",
        bus.MEM_EN, bus.MEM_WE, bus.BUSY, bus.MDR, bus.MEM_ADDR);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.R || bus.UNALIGNED || bus.TIMEOUT_ERR) r_seen++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (r_seen !== 0) begin errors++; $display("FAIL rm_pulse got %0d exp 0", r_seen); end
    run_access(16'h3100, 1'b0, 1'b1, 16'h0000, 16'hCAFE, 1);
    checks++; if (r_cnt !== 1 || r_at !== 2 || bus.MDR !== 16'hCAFE) begin
      errors++; $display("FAIL rm_after got r %0d at %0d mdr %h exp 1 2 cafe", r_cnt, r_at, bus.MDR); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_word_read;
    test_byte_read;
    test_write;
    test_unaligned;
    test_timeout;
    test_busy_ignore;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
